// File: rtl/display_pkg.sv
// Shared display types: driver modes, bus widths, arbiter state encoding, payload struct.
package display_pkg;

    localparam logic [1:0] MODE_DEC  = 2'd0;
    localparam logic [1:0] MODE_HEX  = 2'd1;
    localparam logic [1:0] MODE_TIME = 2'd2;

    localparam int unsigned DISP_NUM_W = 39;
    localparam int unsigned DISP_PT_W  = 8;

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_GRANT = 2'd1;
    localparam logic [1:0] ARB_HOLD  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = ARB_IDLE,
        ST_GRANT = ARB_GRANT,
        ST_HOLD  = ARB_HOLD
    } arb_state_e;

    typedef struct packed {
        logic [1:0]            mode;
        logic [DISP_NUM_W-1:0] number;
        logic [DISP_PT_W-1:0]  points;
    } disp_payload_t;

    // Reserved mode 3 is shown as min:sec.ms
    function automatic logic [1:0] coerce_mode(input logic [1:0] m);
        return (m == 2'd3) ? MODE_TIME : m;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick generator: free-running prescaler, one-cycle tick at each wrap.
module ms_tick_gen #(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int unsigned DIV   = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Next prescaler count and wrap pulse
    always_comb begin
        tick_d = (cnt_q == CNT_W'(DIV - 1));
        cnt_d  = tick_d ? '0 : cnt_q + CNT_W'(1);
    end

    // Prescaler registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/display_arbiter.sv
// Round-robin owner selection for the seven-segment driver with a minimum hold time.
// Optional: define DISPLAY_ARB_PREEMPT_EN to let requester 0 preempt any other owner.
module display_arbiter
    import display_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned HOLD_MS = 2000
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [2*NUM_REQ-1:0]          req_mode,
    input  logic [DISP_NUM_W*NUM_REQ-1:0] req_number,
    input  logic [DISP_PT_W*NUM_REQ-1:0]  req_points,
    output logic [NUM_REQ-1:0]            req_grant,
    output logic [1:0]                    disp_mode,
    output logic [DISP_NUM_W-1:0]         disp_number,
    output logic [DISP_PT_W-1:0]          disp_points,
    output logic                          owner_valid
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned HC_W  = $clog2(HOLD_MS + 1);

    logic tick;

    ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    // Per-requester views of the flattened request buses
    logic [1:0]            mode_a [NUM_REQ];
    logic [DISP_NUM_W-1:0] num_a  [NUM_REQ];
    logic [DISP_PT_W-1:0]  pt_a   [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign mode_a[g] = req_mode[2*g +: 2];
        assign num_a[g]  = req_number[DISP_NUM_W*g +: DISP_NUM_W];
        assign pt_a[g]   = req_points[DISP_PT_W*g +: DISP_PT_W];
    end

    // First valid index at or after ptr, searching upward with wrap
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] idx;
        logic             found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            idx = IDX_W'((int'(ptr) + k) % int'(NUM_REQ));
            if (!found && v[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    arb_state_e           state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 ov_q, ov_d;
    disp_payload_t        disp_q, disp_d;
    logic [IDX_W-1:0]     rr_q, rr_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [HC_W-1:0]      hold_q, hold_d;
    logic [IDX_W-1:0]     winner;
`ifdef DISPLAY_ARB_PREEMPT_EN
    logic                 req0_q, req0_d;
    logic                 preempt_q, preempt_d;
`endif

    // Next-state, grant and display payload selection
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ov_d    = ov_q;
        disp_d  = disp_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        winner  = rr_pick(req_valid, rr_q);
`ifdef DISPLAY_ARB_PREEMPT_EN
        req0_d    = req_valid[0];
        preempt_d = 1'b0;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (|req_valid) state_d = ST_GRANT;
            end

            ST_GRANT: begin
                if (!(|req_valid)) begin
                    // Request vanished before it could be served
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ov_d    = 1'b0;
                end else begin
                    rr_d = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
`ifdef DISPLAY_ARB_PREEMPT_EN
                    // Preemptive grant goes to 0 and leaves the rotation untouched
                    if (preempt_q && req_valid[0]) begin
                        winner = '0;
                        rr_d   = rr_q;
                    end
`endif
                    owner_d       = winner;
                    grant_d       = NUM_REQ'(1) << winner;
                    ov_d          = 1'b1;
                    hold_d        = '0;
                    disp_d.mode   = coerce_mode(mode_a[winner]);
                    disp_d.number = num_a[winner];
                    disp_d.points = pt_a[winner];
                    state_d       = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (!req_valid[owner_q]) begin
                    // Owner gone: release, leave last value on screen
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ov_d    = 1'b0;
                end else begin
                    disp_d.mode   = coerce_mode(mode_a[owner_q]);
                    disp_d.number = num_a[owner_q];
                    disp_d.points = pt_a[owner_q];
                    if (tick && (hold_q != HC_W'(HOLD_MS))) hold_d = hold_q + HC_W'(1);
`ifdef DISPLAY_ARB_PREEMPT_EN
                    if (req_valid[0] && !req0_q && (owner_q != '0)) begin
                        state_d   = ST_GRANT;
                        preempt_d = 1'b1;
                    end else
`endif
                    if ((hold_q == HC_W'(HOLD_MS)) && (|(req_valid & ~grant_q))) begin
                        state_d = ST_GRANT;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                ov_d    = 1'b0;
            end
        endcase
    end

    // Arbiter state and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            ov_q          <= 1'b0;
            disp_q.mode   <= MODE_HEX;
            disp_q.number <= '0;
            disp_q.points <= '0;
            rr_q          <= '0;
            owner_q       <= '0;
            hold_q        <= '0;
`ifdef DISPLAY_ARB_PREEMPT_EN
            req0_q        <= 1'b0;
            preempt_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            ov_q          <= ov_d;
            disp_q        <= disp_d;
            rr_q          <= rr_d;
            owner_q       <= owner_d;
            hold_q        <= hold_d;
`ifdef DISPLAY_ARB_PREEMPT_EN
            req0_q        <= req0_d;
            preempt_q     <= preempt_d;
`endif
        end
    end

    assign req_grant   = grant_q;
    assign owner_valid = ov_q;
    assign disp_mode   = disp_q.mode;
    assign disp_number = disp_q.number;
    assign disp_points = disp_q.points;

endmodule

// File: tb/tb_display_arbiter.sv
// Scoreboard bench for display_arbiter (CLK_HZ=1000 -> tick every cycle, HOLD_MS=4).
module tb_display_arbiter;

    localparam int unsigned NREQ = 4;

    logic             clock;
    logic             reset;
    logic [NREQ-1:0]  req_valid;
    logic [2*NREQ-1:0]  req_mode;
    logic [39*NREQ-1:0] req_number;
    logic [8*NREQ-1:0]  req_points;
    logic [NREQ-1:0]  req_grant;
    logic [1:0]       disp_mode;
    logic [38:0]      disp_number;
    logic [7:0]       disp_points;
    logic             owner_valid;

    display_arbiter #(.NUM_REQ(NREQ), .CLK_HZ(1000), .HOLD_MS(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_mode    (req_mode),
        .req_number  (req_number),
        .req_points  (req_points),
        .req_grant   (req_grant),
        .disp_mode   (disp_mode),
        .disp_number (disp_number),
        .disp_points (disp_points),
        .owner_valid (owner_valid)
    );

    typedef struct {
        int          cyc;   // -1: any cycle
        logic [3:0]  g;
        logic        ov;
        logic [1:0]  m;
        logic [38:0] n;
        logic [7:0]  p;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   done = 0;
    int   c;
    logic [53:0] prev_s, cur_s;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [1:0] m, input logic [38:0] n,
                           input logic [7:0] p);
        req_mode[idx*2 +: 2]    = m;
        req_number[idx*39 +: 39] = n;
        req_points[idx*8 +: 8]  = p;
    endtask

    task automatic expect_out(input int at, input logic [3:0] g, input logic ov,
                              input logic [1:0] m, input logic [38:0] n,
                              input logic [7:0] p, input string name);
        exp_t x;
        x.cyc = at; x.g = g; x.ov = ov; x.m = m; x.n = n; x.p = p; x.name = name;
        exp_q.push_back(x);
    endtask

    // Monitor: invariant every cycle, scoreboard pop on every output change
    initial begin
        prev_s = 'x;
        while (!done) begin
            @(negedge clock);
            cur_s = {req_grant, owner_valid, disp_mode, disp_number, disp_points};
            total++;
            if (!$onehot0(req_grant) || (owner_valid !== (|req_grant))) begin
                bad++;
                $display("FAIL onehot cyc=%0d: got grant=%b ov=%b, need one-hot/zero grant and ov==|grant",
                         cyc, req_grant, owner_valid);
            end
            if (cur_s !== prev_s) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change cyc=%0d: got grant=%b ov=%b mode=%0d num=%0d pts=%h, need no change",
                             cyc, req_grant, owner_valid, disp_mode, disp_number, disp_points);
                end else begin
                    e = exp_q.pop_front();
                    if ((e.cyc >= 0 && e.cyc != cyc) || req_grant !== e.g || owner_valid !== e.ov ||
                        disp_mode !== e.m || disp_number !== e.n || disp_points !== e.p) begin
                        bad++;
                        $display("FAIL %s: got cyc=%0d grant=%b ov=%b mode=%0d num=%0d pts=%h, need cyc=%0d grant=%b ov=%b mode=%0d num=%0d pts=%h",
                                 e.name, cyc, req_grant, owner_valid, disp_mode, disp_number, disp_points,
                                 e.cyc, e.g, e.ov, e.m, e.n, e.p);
                    end
                end
            end
            prev_s = cur_s;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending: got %0d expected events never seen (first %s), need 0",
                     exp_q.size(), exp_q[0].name);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test by 100000, need completion");
        $fatal(1);
    end

    // Stimulus
    initial begin
        reset = 1'b1; req_valid = '0; req_mode = '0; req_number = '0; req_points = '0;
        expect_out(-1, 4'b0000, 1'b0, 2'd1, 39'd0, 8'h00, "reset_init");
        step(3);
        reset = 1'b0;
        step(2);

        // Single requester, 2-clock latency, live tracking, then release
        set_req(1, 2'd0, 39'd1234, 8'h00); req_valid = 4'b0010; c = cyc;
        expect_out(c + 2, 4'b0010, 1'b1, 2'd0, 39'd1234, 8'h00, "t2_grant");
        step(2);
        set_req(1, 2'd0, 39'd1235, 8'h00);
        expect_out(c + 3, 4'b0010, 1'b1, 2'd0, 39'd1235, 8'h00, "t2_track");
        step(3); c = cyc; req_valid = 4'b0000;
        expect_out(c + 1, 4'b0000, 1'b0, 2'd0, 39'd1235, 8'h00, "t2_drop");
        step(2);

        // Reset in the middle of owner 2's hold
        set_req(2, 2'd1, 39'h12345, 8'h05); req_valid = 4'b0100; c = cyc;
        expect_out(c + 2, 4'b0100, 1'b1, 2'd1, 39'h12345, 8'h05, "t1_grant");
        step(4);
        reset = 1'b1; req_valid = 4'b0000;
        expect_out(cyc, 4'b0000, 1'b0, 2'd1, 39'd0, 8'h00, "t1_reset");
        step(2);
        reset = 1'b0;
        step(2);

        // Round-robin among 0,1,3 with 6-cycle owner periods
        set_req(0, 2'd0, 39'd111, 8'h01);
        set_req(1, 2'd1, 39'd222, 8'h00);
        set_req(3, 2'd2, 39'd333, 8'h14);
        req_valid = 4'b1011; c = cyc;
        expect_out(c + 2,  4'b0001, 1'b1, 2'd0, 39'd111, 8'h01, "t3_own0");
        expect_out(c + 8,  4'b0010, 1'b1, 2'd1, 39'd222, 8'h00, "t3_own1");
        expect_out(c + 14, 4'b1000, 1'b1, 2'd2, 39'd333, 8'h14, "t3_own3");
        expect_out(c + 20, 4'b0001, 1'b1, 2'd0, 39'd111, 8'h01, "t3_own0b");
        expect_out(c + 26, 4'b0010, 1'b1, 2'd1, 39'd222, 8'h00, "t3_own1b");
        expect_out(c + 32, 4'b1000, 1'b1, 2'd2, 39'd333, 8'h14, "t3_own3b");
        step(33);

        // Owner 3 drops at hold_cnt=1 while its number changes: display stays frozen
        set_req(3, 2'd2, 39'd999, 8'h14); req_valid = 4'b0011;
        expect_out(c + 34, 4'b0000, 1'b0, 2'd2, 39'd333, 8'h14, "t4_drop");
        expect_out(c + 36, 4'b0001, 1'b1, 2'd0, 39'd111, 8'h01, "t4_regrant");
        step(4); req_valid = 4'b0000;
        expect_out(c + 38, 4'b0000, 1'b0, 2'd0, 39'd111, 8'h01, "t4_idle");
        step(2);

        // Mode 3 coercion; lone owner past hold keeps screen, rotates at once when 3 arrives
        set_req(2, 2'd3, 39'd555, 8'h00);
        set_req(3, 2'd1, 39'h3ff, 8'h80);
        req_valid = 4'b0100; c = cyc;
        expect_out(c + 2, 4'b0100, 1'b1, 2'd2, 39'd555, 8'h00, "t5_coerce");
        step(12); req_valid = 4'b1100;
        expect_out(c + 14, 4'b1000, 1'b1, 2'd1, 39'h3ff, 8'h80, "t5_rotate");
        step(3); req_valid = 4'b0000;
        expect_out(c + 16, 4'b0000, 1'b0, 2'd1, 39'h3ff, 8'h80, "t5_idle");
        step(2);

`ifdef DISPLAY_ARB_PREEMPT_EN
        // Requester 0 preempts owner 2; rr pointer stays at 3
        set_req(2, 2'd0, 39'd42, 8'h00);
        set_req(0, 2'd0, 39'd7, 8'h02);
        set_req(3, 2'd0, 39'd77, 8'h00);
        req_valid = 4'b0100; c = cyc;
        expect_out(c + 2, 4'b0100, 1'b1, 2'd0, 39'd42, 8'h00, "t6_own2");
        step(3); req_valid = 4'b1101;
        expect_out(c + 5, 4'b0001, 1'b1, 2'd0, 39'd7, 8'h02, "t6_preempt");
        step(3); req_valid = 4'b1100;
        expect_out(c + 7, 4'b0000, 1'b0, 2'd0, 39'd7, 8'h02, "t6_drop0");
        expect_out(c + 9, 4'b1000, 1'b1, 2'd0, 39'd77, 8'h00, "t6_next3");
        step(4); req_valid = 4'b0000;
        expect_out(c + 11, 4'b0000, 1'b0, 2'd0, 39'd77, 8'h00, "t6_idle");
        step(2);
`endif

        step(5);
        done = 1'b1;
    end

endmodule
